// File: rtl/nand_op_sequencer.sv
// nand_op_sequencer: drives one shared quad 2-input NAND package through a
// fixed per-opcode step sequence to evaluate 4-bit logic operations.
// Requests and responses use valid/ready handshakes.
// Optional build macro NAND_SEQ_PERF_EN adds a saturating EXEC-cycle counter
// (perf_steps).
module nand_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_y,
  output logic             resp_err,
  output logic [WIDTH-1:0] nand_a,
  output logic [WIDTH-1:0] nand_b,
  input  logic [WIDTH-1:0] nand_y
`ifdef NAND_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_steps
`endif
);

  localparam logic [2:0] OP_NAND = 3'd0, OP_AND = 3'd1, OP_OR  = 3'd2,
                         OP_XOR  = 3'd3, OP_NOT = 3'd4, OP_NOR = 3'd5,
                         OP_BUF  = 3'd6, OP_ILL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [1:0]       step_q;
  logic [WIDTH-1:0] a_q, b_q, t1_q, t2_q, t3_q, y_q;
  logic             err_q;
  logic [1:0]       last_step;
  logic             is_last;

  // Index of the final step for the latched opcode (step count - 1).
  always_comb begin
    last_step = 2'd0;
    case (op_q)
      OP_AND, OP_BUF: last_step = 2'd1;
      OP_OR:          last_step = 2'd2;
      OP_XOR, OP_NOR: last_step = 2'd3;
      default:        last_step = 2'd0;
    endcase
  end

  assign is_last = (step_q == last_step);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; illegal opcode skips EXEC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = (req_op == OP_ILL) ? S_RESP : S_EXEC;
      S_EXEC: if (is_last)   state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Outputs: handshake flags and the NAND operand mux for the current step.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    nand_a     = '0;
    nand_b     = '0;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_NAND: begin nand_a = a_q; nand_b = b_q; end
        OP_AND: begin
          if (step_q == 2'd0) begin nand_a = a_q;  nand_b = b_q;  end
          else                begin nand_a = t1_q; nand_b = t1_q; end
        end
        OP_OR: begin
          case (step_q)
            2'd0:    begin nand_a = a_q;  nand_b = a_q;  end
            2'd1:    begin nand_a = b_q;  nand_b = b_q;  end
            default: begin nand_a = t1_q; nand_b = t2_q; end
          endcase
        end
        OP_XOR: begin
          case (step_q)
            2'd0:    begin nand_a = a_q;  nand_b = b_q;  end
            2'd1:    begin nand_a = a_q;  nand_b = t1_q; end
            2'd2:    begin nand_a = b_q;  nand_b = t1_q; end
            default: begin nand_a = t2_q; nand_b = t3_q; end
          endcase
        end
        OP_NOT: begin nand_a = a_q; nand_b = a_q; end
        OP_NOR: begin
          case (step_q)
            2'd0:    begin nand_a = a_q;  nand_b = a_q;  end
            2'd1:    begin nand_a = b_q;  nand_b = b_q;  end
            2'd2:    begin nand_a = t1_q; nand_b = t2_q; end
            default: begin nand_a = t3_q; nand_b = t3_q; end
          endcase
        end
        OP_BUF: begin
          if (step_q == 2'd0) begin nand_a = a_q;  nand_b = a_q;  end
          else                begin nand_a = t1_q; nand_b = t1_q; end
        end
        default: begin nand_a = '0; nand_b = '0; end
      endcase
    end
  end

  // Datapath: latch request, capture NAND output into T(step+1) or the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NAND;
      a_q    <= '0;
      b_q    <= '0;
      t1_q   <= '0;
      t2_q   <= '0;
      t3_q   <= '0;
      y_q    <= '0;
      err_q  <= 1'b0;
      step_q <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          op_q   <= req_op;
          a_q    <= req_a;
          b_q    <= req_b;
          step_q <= 2'd0;
          if (req_op == OP_ILL) begin
            y_q   <= '0;
            err_q <= 1'b1;
          end else begin
            err_q <= 1'b0;
          end
        end
        S_EXEC: begin
          if (is_last) begin
            y_q    <= nand_y;
            step_q <= 2'd0;
          end else begin
            case (step_q)
              2'd0:    t1_q <= nand_y;
              2'd1:    t2_q <= nand_y;
              default: t3_q <= nand_y;
            endcase
            step_q <= step_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_y   = y_q;
  assign resp_err = err_q;

`ifdef NAND_SEQ_PERF_EN
  // Saturating count of EXEC cycles; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          perf_steps <= '0;
    else if (state_q == S_EXEC && perf_steps != 16'hFFFF) perf_steps <= perf_steps + 16'd1;
  end
`endif

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Self-checking bench for nand_op_sequencer with a behavioural ls7400 model.
module tb_nand_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [2:0] req_op;
  logic [3:0] req_a, req_b, resp_y, nand_a, nand_b, nand_y;
`ifdef NAND_SEQ_PERF_EN
  logic [15:0] perf_steps;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // ls7400 behavioural model
  assign nand_y = ~(nand_a & nand_b);

  nand_op_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_y(resp_y), .resp_err(resp_err),
    .nand_a(nand_a), .nand_b(nand_b), .nand_y(nand_y)
`ifdef NAND_SEQ_PERF_EN
    , .perf_steps(perf_steps)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_y(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return ~(a & b);
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~a;
      3'd5: return ~(a | b);
      3'd6: return a;
      default: return 4'h0;
    endcase
  endfunction

  // cycle at which resp_valid first appears (handshake is cycle 0)
  function automatic int ref_lat(input logic [2:0] op);
    int steps[8] = '{1, 2, 3, 4, 1, 4, 2, 0};
    return steps[op] + 1;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input int hold);
    int c;
    bit seen;
    logic [3:0] ey;
    logic [3:0] xa[4] = '{4'hF, 4'hF, 4'h5, 4'h5};
    logic [3:0] xb[4] = '{4'h5, 4'hA, 4'hA, 4'hF};
    ey = ref_y(op, a, b);
    @(negedge clk);
    chk("req_ready_idle", {15'd0, req_ready}, 16'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    resp_ready = (hold == 0);
    @(posedge clk);
    c = 0; seen = 0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (op == 3'd3 && a == 4'hF && b == 4'h5 && c <= 4) begin
        chk("xor_nand_a", {12'd0, nand_a}, {12'd0, xa[c-1]});
        chk("xor_nand_b", {12'd0, nand_b}, {12'd0, xb[c-1]});
      end
      if (resp_valid) seen = 1;
      req_valid = 1'b0;
      req_a = 4'($urandom); req_b = 4'($urandom); req_op = 3'($urandom);
    end
    chk("resp_seen", {15'd0, seen}, 16'd1);
    chk("latency", 16'(c), 16'(ref_lat(op)));
    chk("resp_y", {12'd0, resp_y}, {12'd0, ey});
    chk("resp_err", {15'd0, resp_err}, {15'd0, op == 3'd7});
    chk("nand_ab_resp", {8'd0, nand_a, nand_b}, 16'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_y", {12'd0, resp_y}, {12'd0, ey});
      chk("hold_valid_ready", {14'd0, resp_valid, req_ready}, 16'b10);
      req_a = 4'($urandom); req_op = 3'($urandom);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("after_resp", {14'd0, resp_valid, req_ready}, 16'b01);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; resp_ready = 0;
    #12;
    chk("rst_flags", {13'd0, req_ready, resp_valid, resp_err}, 16'b100);
    chk("rst_y", {12'd0, resp_y}, 16'd0);
    chk("rst_nand", {8'd0, nand_a, nand_b}, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(3'd3, 4'hC, 4'hA, 0);
    do_op(3'd5, 4'hC, 4'hA, 0);
`ifdef NAND_SEQ_PERF_EN
    chk("perf_steps", perf_steps, 16'd8);
`endif
    for (int op = 0; op < 8; op++) do_op(3'(op), 4'hC, 4'hA, 0);
    do_op(3'd3, 4'hF, 4'h5, 0);
    do_op(3'd2, 4'hC, 4'hA, 5);

    // reset during XOR step 2
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_a = 4'hC; req_b = 4'hA; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {13'd0, req_ready, resp_valid, resp_err}, 16'b100);
    chk("mid_rst_y", {12'd0, resp_y}, 16'd0);
    chk("mid_rst_nand", {8'd0, nand_a, nand_b}, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) bad++;
    end
    chk("no_resp_after_rst", 16'(bad), 16'd0);
    do_op(3'd1, 4'hC, 4'hA, 0);

    for (int i = 0; i < 30; i++)
      do_op(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/nand_op_sequencer.md
Name: nand_op_sequencer

Overview:
Controller that time-multiplexes a single external quad 2-input NAND package (ls7400) to evaluate 4-bit logic operations. Accepts one request at a time over a valid/ready handshake and drives the NAND inputs through a fixed per-opcode step sequence. It captures each NAND output into temporaries and returns the final value over a valid/ready response channel. It sits between the CPU control path and the shared ls7400 datapath instance.

Parameters:
WIDTH, 4, operand/result width; equals the NAND lanes of the attached package (4 for ls7400).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request; high only in IDLE
req_op  input  3  opcode: 000 NAND, 001 AND, 010 OR, 011 XOR, 100 NOT A, 101 NOR, 110 BUF A, 111 illegal
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B (ignored by NOT/BUF)
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_y  output  WIDTH  result
resp_err  output  1  illegal opcode flag, qualified by resp_valid
nand_a  output  WIDTH  to ls7400 input a
nand_b  output  WIDTH  to ls7400 input b
nand_y  input  WIDTH  from ls7400 output y (combinational, settles within one cycle)

Behaviour:
- States: IDLE, EXEC (step index 0..3), RESP.
- Reset (async, rst_n low): state IDLE, req_ready 1, resp_valid 0, resp_y 0, resp_err 0, nand_a/nand_b 0, temporaries T1..T3 0, step 0.
- IDLE: req_ready=1. On req_valid&&req_ready at an edge: latch op/A/B. Go to EXEC step 0, or directly to RESP for op 111.
- EXEC: one NAND step per cycle. nand_a/nand_b are driven from latched operands and temporaries per the table below. nand_y is captured at the end-of-cycle edge. After the last step, the final capture goes to resp_y and the state moves to RESP.
- Step table (step: inputs -> destination):
  NAND: s0 (A,B)->Y
  AND: s0 (A,B)->T1; s1 (T1,T1)->Y
  OR: s0 (A,A)->T1; s1 (B,B)->T2; s2 (T1,T2)->Y
  XOR: s0 (A,B)->T1; s1 (A,T1)->T2; s2 (B,T1)->T3; s3 (T2,T3)->Y
  NOT: s0 (A,A)->Y
  NOR: s0 (A,A)->T1; s1 (B,B)->T2; s2 (T1,T2)->T3; s3 (T3,T3)->Y
  BUF: s0 (A,A)->T1; s1 (T1,T1)->Y
- Illegal op 111: no EXEC cycles. Enters RESP with resp_y=0, resp_err=1.
- Latency: handshake in cycle 0; EXEC occupies cycles 1..N (N=step count); resp_valid high from cycle N+1. For op 111, resp_valid is high in cycle 1.
- RESP: resp_valid=1; resp_y and resp_err held stable until resp_valid&&resp_ready at an edge. Then go to IDLE; req_ready rises the following cycle (no same-cycle turnaround).
- nand_a/nand_b = 0 in IDLE and RESP.
- req_* changes while not in IDLE are ignored; operands stay latched.
- resp_err=0 for all legal ops.
- Reset asserted mid-EXEC or mid-RESP aborts the operation. No response is produced, and the block comes up in IDLE.

Optional Feature:
Macro NAND_SEQ_PERF_EN.
- Defined: adds output perf_steps (16 bits), counting every EXEC cycle. Saturates at 16'hFFFF; reset value 0; cleared only by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Bench setup: behavioural ls7400 model on nand_a/nand_b/nand_y; A=1100, B=1010 unless stated.
- Each op issued with resp_ready=1 -> NAND 0111 (resp_valid in cycle 2), AND 1000 (cycle 3), OR 1110 (cycle 4), XOR 0110 (cycle 5), NOT 0011 (cycle 2), NOR 0001 (cycle 5), BUF 1100 (cycle 3); resp_err=0 for all.
- XOR A=1111 B=0101: per-cycle nand inputs (1111,0101), (1111,1010), (0101,1010), (0101,1111) -> resp_y=1010.
- Op 111 -> resp_valid in cycle 1, resp_y=0000, resp_err=1, nand_a/nand_b stay 0.
- Backpressure: OR with resp_ready=0 for 5 cycles -> resp_y=1110 held stable, req_ready=0. Toggling req_a/req_op meanwhile has no effect. After the resp_ready handshake, req_ready=1 one cycle later.
- Reset: rst_n pulsed low during XOR step 2 -> all outputs return to reset values immediately; no resp_valid afterwards. A following AND returns 1000.
- Perf: with NAND_SEQ_PERF_EN, issue XOR then NOR -> perf_steps=8. Preloading near 16'hFFFF confirms saturation.
